serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor with borrow-in/borrow-out. Computes a - b - bin, one bit per clock, LSB first.
//   Inverse-direction companion to the team's parallel adder. Used where area matters more than throughput.
//   Operands are accepted and results returned through valid/ready handshakes, so it drops into streaming datapaths.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
// PORTS
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous reset, active-low
//   in_valid   input   1      a/b/bin valid
//   in_ready   output  1      block can accept operands (state==IDLE)
//   a          input   WIDTH  minuend
//   b          input   WIDTH  subtrahend
//   bin        input   1      borrow-in
//   out_valid  output  1      diff/bout valid (state==DONE)
//   out_ready  input   1      downstream accepts result
//   diff       output  WIDTH  difference, registered
//   bout       output  1      borrow-out, registered
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, count=0, diff=0, bout=0, out_valid=0, in_ready=1; internal regs cleared.
//   Result identity: {bout,diff} == ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1).
//   FSM states IDLE, RUN, DONE:
//   - IDLE: in_ready=1. On in_valid&in_ready at edge k: latch a,b, set borrow=bin, count=0, diff=0 -> RUN.
//   - RUN: in_ready=0, out_valid=0. Each edge processes bit i=count:
//       d_i = a[i]^b[i]^br;  br' = (~a[i]&b[i]) | (~(a[i]^b[i])&br).
//     d_i shifts into diff MSB (diff <= {d_i, diff[WIDTH-1:1]}); count++.
//     On the edge processing bit WIDTH-1 (edge k+WIDTH): bout<=br' -> DONE.
//   - DONE: out_valid=1; diff/bout held stable. On out_valid&out_ready -> IDLE.
//     out_valid falls next cycle; diff/bout keep their last value until the next RUN begins.
//   Latency: out_valid rises exactly WIDTH clocks after the accepting edge. Throughput: 1 op per WIDTH+2 clocks
//     when out_ready is held high.
//   in_valid during RUN/DONE is ignored (in_ready=0); operand inputs may change freely after acceptance.
//   No combinational path from inputs to outputs; in_ready/out_valid decode from the state register only.
//   count width = $clog2(WIDTH); never exceeds WIDTH-1; illegal state encodings -> IDLE.
//   Reset mid-RUN or mid-DONE aborts the operation immediately; no partial result is ever flagged valid.
// TESTING
//   1 WIDTH=4: a=9,b=3,bin=0 -> out_valid 4 clks after accept, diff=6, bout=0.
//   2 a=3,b=9,bin=0 -> diff=4'hA, bout=1; a=0,b=0,bin=1 -> diff=4'hF, bout=1; a=F,b=F,bin=1 -> diff=F, bout=1.
//   3 Backpressure: out_ready=0 for 5 clks after out_valid -> diff/bout/out_valid stable, in_ready=0 throughout;
//     out_ready=1 -> IDLE, in_ready=1 next clk.
//   4 in_valid held high with new operands during RUN -> ignored; result matches first operands only.
//   5 rst_n low at RUN count=2 -> out_valid=0, diff=0, bout=0, in_ready=1 immediately (async); next op correct.
//   6 Random: 10k ops, random valid/ready gaps, WIDTH=4 and 8 -> every result matches identity; op count in==out.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock, LSB first.
// Operands enter through a valid/ready handshake; the result leaves through another.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             br;
  logic [CW-1:0]    count;
  logic             last;
  logic             d_bit, br_nxt;

  assign last   = (count == CW'(WIDTH - 1));
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  // Handshake outputs decode from the state register only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operands shift right so the active bit always sits at position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      count <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          br    <= bin;
          count <= '0;
          diff  <= '0;
        end
        RUN: begin
          diff <= {d_bit, diff[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          if (last) begin
            bout  <= br_nxt;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
